// File: rtl/sram_wb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge.
// Holds the FSM state enum, the word-width derivation and the byte-offset width.
package sram_bridge_pkg;

    // Low address bits that select a byte within a word; the SRAM is word-addressed.
    localparam int BYTE_OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic int word_size(input int byte_count);
        return 8 * byte_count;
    endfunction

endpackage

// File: rtl/sram_wb_bridge_if.sv
// Wishbone classic bus bundle between a bus master and the sram_wb_bridge slave.
// Carries the cycle/strobe request, the write payload, and the ack/read-data/busy response.
interface sram_wb_bridge_if
    import sram_bridge_pkg::*;
#(
    parameter int BYTE_COUNT   = 4,
    parameter int ADDRESS_SIZE = 9
);
    localparam int WORD_SIZE = word_size(BYTE_COUNT);

    // Handshake: a transfer is offered while wbCyc & wbStb are high and is taken on
    // the first edge the slave is idle; the slave then raises wbAck for exactly one
    // cycle (only while wbCyc is still high), and wbBusy marks every non-idle cycle.
    logic                                  wbCyc;
    logic                                  wbStb;
    logic                                  wbWe;
    logic [BYTE_COUNT-1:0]                 wbSel;
    logic [ADDRESS_SIZE+BYTE_OFFSET_W-1:0] wbAddress;
    logic [WORD_SIZE-1:0]                  wbDataWrite;
    logic                                  wbAck;
    logic [WORD_SIZE-1:0]                  wbDataRead;
    logic                                  wbBusy;

    modport master (
        output wbCyc, wbStb, wbWe, wbSel, wbAddress, wbDataWrite,
        input  wbAck, wbDataRead, wbBusy
    );

    modport slave (
        input  wbCyc, wbStb, wbWe, wbSel, wbAddress, wbDataWrite,
        output wbAck, wbDataRead, wbBusy
    );

endinterface

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave driving the primary RW port of a one-cycle-latency SRAM.
// Define SRAM_READ_REG_EN to register SRAM read data for one extra cycle before the ack.
module sram_wb_bridge
    import sram_bridge_pkg::*;
#(
    parameter  int BYTE_COUNT   = 4,
    parameter  int ADDRESS_SIZE = 9,
    localparam int WORD_SIZE    = word_size(BYTE_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_wb_bridge_if.slave         wb,
    output logic                    sramSelect,
    output logic                    sramWriteEnable,
    output logic [BYTE_COUNT-1:0]   sramWriteMask,
    output logic [ADDRESS_SIZE-1:0] sramAddress,
    output logic [WORD_SIZE-1:0]    sramDataWrite,
    input  logic [WORD_SIZE-1:0]    sramDataRead,
    output state_t                  debug_state
);

    state_t               state;
    logic                 last_read;
    logic                 request;
    logic [WORD_SIZE-1:0] read_source;
    logic                 unused_addr_bits;

    // Reset gates the request so the SRAM is never selected while rst is high.
    assign request = wb.wbCyc & wb.wbStb & (state == IDLE) & ~rst;

    assign sramSelect       = request;
    assign sramWriteEnable  = request & wb.wbWe;
    assign sramWriteMask    = wb.wbWe ? wb.wbSel : '0;
    assign sramAddress      = wb.wbAddress[ADDRESS_SIZE+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
    assign sramDataWrite    = wb.wbDataWrite;
    assign unused_addr_bits = ^wb.wbAddress[BYTE_OFFSET_W-1:0];

    assign wb.wbAck     = (state == ACK) & wb.wbCyc & ~rst;
    assign wb.wbBusy    = (state != IDLE) & ~rst;
    assign wb.wbDataRead = (last_read & ~rst) ? read_source : '0;
    assign debug_state  = state;

`ifdef SRAM_READ_REG_EN
    logic [WORD_SIZE-1:0] read_data;
    assign read_source = read_data;
`else
    assign read_source = sramDataRead;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_read <= 1'b0;
`ifdef SRAM_READ_REG_EN
            read_data <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        last_read <= ~wb.wbWe;
`ifdef SRAM_READ_REG_EN
                        state     <= wb.wbWe ? ACK : READ;
`else
                        state     <= ACK;
`endif
                    end
                end
`ifdef SRAM_READ_REG_EN
                // SRAM output is valid here; capture it whether or not wbCyc is still high.
                READ: begin
                    read_data <= sramDataRead;
                    state     <= ACK;
                end
`endif
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
